// File: rtl/traffic_pkg.sv
// Shared state encodings, direction constants and lamp decode for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_e;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    // Unknown encodings fall back to both heads red so a corrupted state never shows a green.
    function automatic lamps_t decode_lamps(input state_e st);
        lamps_t l;
        l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
              ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
        case (st)
            NS_GREEN:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
            NS_YELLOW: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
            EW_GREEN:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
            EW_YELLOW: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
            PED_WALK:  l.walk = 1'b1;
            default:   l.walk = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-paced phase timer: clears on phase change, can saturate, flags the last tick of a duration.
import traffic_pkg::*;

module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               i_clr,
    input  logic               i_sat,
    input  logic [TIMER_W-1:0] i_dur,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // Tick counter; clear has priority over saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {TIMER_W{1'b0}};
        end else if (i_tick) begin
            if (i_clr) begin
                r_count <= {TIMER_W{1'b0}};
            end else if (!i_sat) begin
                r_count <= r_count + TIMER_W'(1);
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count >= (i_dur - TIMER_W'(1)));

endmodule

// File: rtl/intersection_scheduler.sv
// Right-of-way scheduler for two vehicle approaches plus a pedestrian crossing, paced by slow_tick.
import traffic_pkg::*;

module intersection_scheduler #(
    parameter int MIN_GREEN        = 3,
    parameter int MAX_GREEN        = 6,
    parameter int YELLOW_DURATION  = 2,
    parameter int ALL_RED_DURATION = 1,
    parameter int WALK_DURATION    = 4,
    parameter int TIMER_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [TIMER_W-1:0] L_MIN  = TIMER_W'(MIN_GREEN);
    localparam logic [TIMER_W-1:0] L_MAX  = TIMER_W'(MAX_GREEN);
    localparam logic [TIMER_W-1:0] L_YEL  = TIMER_W'(YELLOW_DURATION);
    localparam logic [TIMER_W-1:0] L_AR   = TIMER_W'(ALL_RED_DURATION);
    localparam logic [TIMER_W-1:0] L_WALK = TIMER_W'(WALK_DURATION);

    state_e             r_state;
    state_e             w_next_state;
    logic               r_last_served;
    logic               r_ped_pending;
    logic [TIMER_W-1:0] w_timer;
    logic [TIMER_W-1:0] w_dur;
    logic               w_done;
    logic               w_min_ok;
    logic               w_clr;
    logic               w_sat;
    lamps_t             w_lamps;

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (slow_tick),
        .i_clr   (w_clr),
        .i_sat   (w_sat),
        .i_dur   (w_dur),
        .o_count (w_timer),
        .o_done  (w_done)
    );

    // Duration that the timer's done flag compares against in each phase.
    always_comb begin
        w_dur = L_AR;
        case (r_state)
            ALL_RED:              w_dur = L_AR;
            NS_GREEN, EW_GREEN:   w_dur = L_MAX;
            NS_YELLOW, EW_YELLOW: w_dur = L_YEL;
            PED_WALK:             w_dur = L_WALK;
            default:              w_dur = L_AR;
        endcase
    end

    assign w_min_ok = (w_timer >= (L_MIN - TIMER_W'(1)));

    // Next-state arbitration; idle ALL_RED and demand-free green hold with the timer saturated.
    always_comb begin
        w_next_state = r_state;
        w_sat        = 1'b0;
        case (r_state)
            ALL_RED: begin
                if (!w_done) begin
                    w_next_state = ALL_RED;
                end else if (r_ped_pending) begin
                    w_next_state = PED_WALK;
                end else if (ns_req && ew_req) begin
                    w_next_state = (r_last_served == DIR_NS) ? EW_GREEN : NS_GREEN;
                end else if (ns_req) begin
                    w_next_state = NS_GREEN;
                end else if (ew_req) begin
                    w_next_state = EW_GREEN;
                end else begin
                    w_sat = 1'b1;
                end
            end
            NS_GREEN: begin
                if ((ew_req || r_ped_pending) && (w_min_ok || w_done)) begin
                    w_next_state = NS_YELLOW;
                end else if (w_min_ok) begin
                    w_sat = 1'b1;
                end else begin
                    w_next_state = NS_GREEN;
                end
            end
            EW_GREEN: begin
                if ((ns_req || r_ped_pending) && (w_min_ok || w_done)) begin
                    w_next_state = EW_YELLOW;
                end else if (w_min_ok) begin
                    w_sat = 1'b1;
                end else begin
                    w_next_state = EW_GREEN;
                end
            end
            NS_YELLOW, EW_YELLOW, PED_WALK: begin
                if (w_done) begin
                    w_next_state = ALL_RED;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ALL_RED;
        endcase
    end

    assign w_clr = (w_next_state != r_state);

    // Phase FSM and fairness memory, advanced only on slow ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ALL_RED;
            r_last_served <= DIR_EW;
        end else if (slow_tick) begin
            r_state <= w_next_state;
            if (r_state == NS_YELLOW && w_next_state == ALL_RED) begin
                r_last_served <= DIR_NS;
            end else if (r_state == EW_YELLOW && w_next_state == ALL_RED) begin
                r_last_served <= DIR_EW;
            end else begin
                r_last_served <= r_last_served;
            end
        end else begin
            r_state       <= r_state;
            r_last_served <= r_last_served;
        end
    end

    // Pedestrian request latch; entering the walk phase serves (and clears) a coincident press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ped_pending <= 1'b0;
        end else if (slow_tick && (w_next_state == PED_WALK) && (r_state != PED_WALK)) begin
            r_ped_pending <= 1'b0;
        end else if (ped_req) begin
            r_ped_pending <= 1'b1;
        end else begin
            r_ped_pending <= r_ped_pending;
        end
    end

    assign w_lamps     = decode_lamps(r_state);
    assign ns_red      = w_lamps.ns_red;
    assign ns_yellow   = w_lamps.ns_yellow;
    assign ns_green    = w_lamps.ns_green;
    assign ew_red      = w_lamps.ew_red;
    assign ew_yellow   = w_lamps.ew_yellow;
    assign ew_green    = w_lamps.ew_green;
    assign walk        = w_lamps.walk;
    assign ped_pending = r_ped_pending;
    assign phase       = r_state;

endmodule
